// File: rtl/ann_pkg.sv
// Shared types and constants for the neuron datapath: accumulator widths, clamp rails
// and the accumulation controller state type.
package ann_pkg;

   localparam int ACC_W = 19;
   localparam int SUM_W = 20;

   // Two's-complement rails of the 19-bit accumulator (+262143 / -262144).
   localparam logic signed [ACC_W-1:0] ACC_MAX = 19'h3FFFF;
   localparam logic signed [ACC_W-1:0] ACC_MIN = 19'h40000;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } acc_state_t;

endpackage

// File: rtl/adder19.sv
// Shared 19-bit signed adder producing the full 20-bit sum; overflow handling is left
// to the caller.
module adder19
   import ann_pkg::*;
(
   input  logic signed [ACC_W-1:0] a,
   input  logic signed [ACC_W-1:0] b,
   output logic signed [SUM_W-1:0] s
);

   assign s = {a[ACC_W-1], a} + {b[ACC_W-1], b};

endmodule

// File: rtl/neuron_acc_ctrl.sv
// Sequences one neuron's bias + N_TERMS weighted-sum reduction through a shared adder,
// clamping to 19 bits after every step and presenting the result on a valid/ready port.
module neuron_acc_ctrl
   import ann_pkg::*;
#(
   parameter int unsigned N_TERMS = 16,
   parameter int unsigned CNT_W   = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [ACC_W-1:0] bias,
   input  logic                    in_valid,
   input  logic signed [ACC_W-1:0] in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_sum,
   output logic                    out_sat,
   output logic                    busy
);

   acc_state_t              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sat_q, sat_d;

   logic signed [SUM_W-1:0] sum;
   logic signed [ACC_W-1:0] sum_clamped;
   logic                    clamped;
   logic                    last_term;

   adder19 u_adder19 (
      .a (acc_q),
      .b (in_data),
      .s (sum)
   );

   // The top two sum bits disagree exactly when the result left the 19-bit range.
   always_comb begin
      clamped = sum[SUM_W-1] ^ sum[SUM_W-2];
      if (!clamped) begin
         sum_clamped = sum[ACC_W-1:0];
      end else if (sum[SUM_W-1]) begin
         sum_clamped = ACC_MIN;
      end else begin
         sum_clamped = ACC_MAX;
      end
   end

   assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = bias;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d = sum_clamped;
               cnt_d = cnt_q + 1'b1;
               sat_d = sat_q | clamped;
               if (last_term) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // Result outputs are gated by DONE so they read zero whenever no result is offered.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign out_sum   = out_valid ? acc_q : '0;
   assign out_sat   = out_valid & sat_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Randomised self-checking bench for neuron_acc_ctrl against a saturating-sum reference.
module tb_neuron_acc_ctrl;

   localparam int NT = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic signed [18:0] bias;
   logic               in_valid;
   logic signed [18:0] in_data;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic signed [18:0] out_sum;
   logic               out_sat;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;

   neuron_acc_ctrl #(
      .N_TERMS (NT),
      .CNT_W   (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: bias plus terms, saturated to the 19-bit range after every step.
   function automatic void model(input int b, input int t[NT], output int sum, output int sat);
      sum = b;
      sat = 0;
      for (int i = 0; i < NT; i++) begin
         sum = sum + t[i];
         if (sum > 262143) begin
            sum = 262143;
            sat = 1;
         end else if (sum < -262144) begin
            sum = -262144;
            sat = 1;
         end
      end
   endfunction

   function automatic int rnd19();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 524287)) - 262144;
         1:       return int'($urandom_range(0, 200)) - 100;
         2:       return 262143 - int'($urandom_range(0, 3000));
         default: return -262144 + int'($urandom_range(0, 3000));
      endcase
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_out_sum"}, int'(out_sum), 0);
      chk({tag, "_out_sat"}, int'(out_sat), 0);
   endtask

   task automatic run_neuron(input int b, input int t[NT], input int gap_pct, input int hold,
                             input bit noise);
      int exp_sum, exp_sat, idx, cyc;
      bit v;
      model(b, t, exp_sum, exp_sat);
      @(negedge clk);
      start     = 1'b1;
      bias      = 19'(b);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      idx   = 0;
      cyc   = 0;
      while (idx < NT && cyc < 200) begin
         chk("accum_in_ready", int'(in_ready), 1);
         chk("accum_out_valid", int'(out_valid), 0);
         chk("accum_busy", int'(busy), 1);
         v        = ($urandom_range(0, 99) >= gap_pct);
         in_valid = v;
         in_data  = 19'(t[idx]);
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            bias  = 19'($urandom);
         end
         @(negedge clk);
         cyc++;
         if (v) idx++;
      end
      if (idx < NT) chk("accum_timeout", idx, NT);
      in_valid = 1'b0;
      start    = 1'b0;
      if (gap_pct == 0) chk("latency_edges", cyc, NT);
      chk("done_out_valid", int'(out_valid), 1);
      chk("done_in_ready", int'(in_ready), 0);
      chk("done_busy", int'(busy), 1);
      chk("done_out_sum", int'(out_sum), exp_sum);
      chk("done_out_sat", int'(out_sat), exp_sat);
      for (int h = 0; h < hold; h++) begin
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 19'($urandom);
         end
         @(negedge clk);
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_out_sum", int'(out_sum), exp_sum);
         chk("hold_out_sat", int'(out_sat), exp_sat);
      end
      // A start coinciding with the return to IDLE must be dropped.
      out_ready = 1'b1;
      start     = noise;
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      check_idle("release");
      @(negedge clk);
      check_idle("post_release");
   endtask

   initial begin
      int t[NT];
      // Reset with start and traffic held active.
      rst_n     = 1'b0;
      start     = 1'b1;
      bias      = 19'sd123;
      in_valid  = 1'b1;
      in_data   = 19'sd5;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      rst_n = 1'b1;
      start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_idle("after_reset");
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      t = '{1, 2, 3, 4};
      run_neuron(10, t, 0, 0, 1'b0);
      t = '{200, -100, 0, 0};
      run_neuron(262000, t, 0, 0, 1'b0);
      t = '{-1, 0, 0, 0};
      run_neuron(-262144, t, 0, 0, 1'b0);
      for (int i = 0; i < NT; i++) t[i] = rnd19();
      run_neuron(100, t, 40, 7, 1'b1);

      // Reset in the middle of a neuron, after two accepted terms.
      @(negedge clk);
      start = 1'b1;
      bias  = 19'sd7;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 19'sd9;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_idle("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("after_mid_reset");
      t = '{5, 5, 5, 5};
      run_neuron(0, t, 0, 0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < NT; i++) t[i] = rnd19();
         run_neuron(rnd19(), t, int'($urandom_range(0, 50)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/neuron_acc_ctrl.md
# neuron_acc_ctrl

Sequencing controller for one neuron's weighted-sum reduction. Uses a single shared `adder19` instance to accumulate a bias plus `N_TERMS` signed 19-bit partial products arriving on a valid/ready stream. It clamps the running sum back to 19 bits after every addition and presents the final sum on an output handshake. It sits between the multiplier array and the activation stage of each hidden/output neuron.

## Interface
Parameters:
- `N_TERMS`, default 16: number of terms accumulated per neuron, after the bias. Legal range 1..1024.
- `CNT_W`, default 10: width of the term counter; must satisfy 2^CNT_W ≥ N_TERMS.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: single-cycle request to begin a neuron; honoured only in IDLE.
- `bias`  in  19 signed: initial accumulator value; sampled on an accepted `start`.
- `in_valid`  in  1: term available.
- `in_data`  in  19 signed: term value.
- `in_ready`  out  1: controller accepts a term this cycle.
- `out_valid`  out  1: `out_sum` valid.
- `out_ready`  in  1: downstream consumes the result.
- `out_sum`  out  19 signed: final clamped sum.
- `out_sat`  out  1: at least one clamp occurred during this neuron.
- `busy`  out  1: high in ACCUM or DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE. Encoding is free.
- **IDLE**
  - `in_ready`=0.
  - On `start`=1: acc←bias, cnt←0, sat←0, next state ACCUM.
- **ACCUM**
  - `in_ready`=1. A term is accepted when `in_valid`&&`in_ready`.
  - On accept: acc←clamp19(acc + in_data), cnt←cnt+1, sat←sat | clamped.
  - The add goes through `adder19` (a=acc, b=in_data, s = 20-bit sum).
  - When the accepted term is the N_TERMS-th (cnt==N_TERMS-1 at accept), next state DONE.
  - Cycles with no accepted term leave acc and cnt unchanged.
- **DONE**
  - `out_valid`=1; `out_sum`=acc; `out_sat`=sat.
  - On `out_ready`=1, next state IDLE. acc is retained, but `out_valid` drops.
- **clamp19 on the 20-bit sum s**
  - s > 262143 → 262143.
  - s < −262144 → −262144.
  - Otherwise s[18:0].
  - "clamped" means s[19] ≠ s[18].
- `start` outside IDLE is ignored: no restart and no queuing.
- `in_valid` in IDLE or DONE is not accepted, because `in_ready`=0.
- The clamp is applied per step, not once at the end. Order of terms therefore matters once saturation occurs.

## Timing
- Reset values, all asynchronous on `rst_n`=0:
  - State IDLE.
  - acc=0, cnt=0, sat=0.
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_sat`=0, `busy`=0.
- Reset asserted mid-ACCUM or mid-DONE aborts the neuron. No output is produced.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid`/`out_ready` to any output.
- Latency:
  - `start` at edge k → `in_ready`=1 from cycle k+1.
  - With `in_valid` held high, the last term is accepted at edge k+N_TERMS and `out_valid`=1 in cycle k+N_TERMS+1.
  - Throughput is one term per cycle.
- DONE with `out_ready` already high: `out_valid` lasts exactly one cycle and the state returns to IDLE.
- `start` in the same cycle the FSM returns to IDLE is not seen. `start` is accepted on the next cycle at earliest, so a minimum of one IDLE cycle separates neurons.
- `out_sum`/`out_sat` are stable for as long as `out_valid`=1.

## Structure
- Shared package `ann_pkg`:
  - `ACC_W`=19, `SUM_W`=20.
  - `ACC_MAX`=262143, `ACC_MIN`=−262144.
  - State enum `acc_state_t` {IDLE, ACCUM, DONE}.
- The single sub-module is the existing `adder19`, instantiated once.
- The clamp and the FSM live in this module. No further hierarchy.

## Test plan
- Reset with `start` held high → after release, all outputs 0 and `in_ready`=0 until the first post-reset edge with `start`.
- Nominal, N_TERMS=4, bias=10, terms 1,2,3,4 with `in_valid` continuously high → `out_sum`=20, `out_sat`=0, `out_valid` 5 cycles after `start`.
- Positive saturation: bias=262000, terms 200,−100,0,0 → clamp to 262143 then 262043, so `out_sum`=262043 and `out_sat`=1.
- Negative saturation: bias=−262144, terms −1,0,0,0 → `out_sum`=−262144, `out_sat`=1.
- Back-pressure and bubbles: random `in_valid` gaps plus `out_ready` low for 7 cycles → sum unchanged by gaps, `out_valid`/`out_sum` held stable for 7 cycles, `start` pulses during ACCUM/DONE ignored.
- Reset asserted after 2 of 4 terms → immediate IDLE with outputs 0. The next `start` with bias=0 and terms 5,5,5,5 → `out_sum`=20.
